// File: rtl/usb_rx_nrzi_decoder_if.sv
// Line-sample inputs and decoded-stream outputs of the USB receive NRZI decoder.
// The slave modport is the decoder side; the master modport is the driver/monitor side.
interface usb_rx_nrzi_decoder_if;
   logic i_dp;
   logic i_dm;
   logic i_sample_valid;
   logic i_rx_en;
   logic o_data;
   logic o_valid;
   logic o_sync_pattern;
   logic o_eop;
   logic o_rx_error;
   logic o_active;

   modport slave (
      input  i_dp,
      input  i_dm,
      input  i_sample_valid,
      input  i_rx_en,
      output o_data,
      output o_valid,
      output o_sync_pattern,
      output o_eop,
      output o_rx_error,
      output o_active
   );

   modport master (
      output i_dp,
      output i_dm,
      output i_sample_valid,
      output i_rx_en,
      input  o_data,
      input  o_valid,
      input  o_sync_pattern,
      input  o_eop,
      input  o_rx_error,
      input  o_active
   );
endinterface

// File: rtl/usb_rx_nrzi_decoder.sv
// USB full-speed receive front end: NRZI decode, SYNC hunt, bit unstuffing and
// EOP / line-error detection, producing a one-bit stream for the deserializer.
module usb_rx_nrzi_decoder #(
   parameter int unsigned SYNC_MIN_ZEROS = 5,
   parameter int unsigned EOP_MIN_SE0    = 2,
   parameter int unsigned STUFF_LEN      = 6
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   usb_rx_nrzi_decoder_if.slave bus
);

   localparam int unsigned ZW = $clog2(SYNC_MIN_ZEROS + 1);
   localparam int unsigned OW = $clog2(STUFF_LEN + 1);
   localparam int unsigned SW = $clog2(EOP_MIN_SE0 + 1);

   localparam logic [ZW-1:0] ZERO_MAX  = ZW'(SYNC_MIN_ZEROS);
   localparam logic [OW-1:0] STUFF_MAX = OW'(STUFF_LEN);
   localparam logic [SW-1:0] SE0_MAX   = SW'(EOP_MIN_SE0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_EOP  = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   state_e        state_q, state_d;
   logic          prev_level_q, prev_level_d;
   logic [ZW-1:0] zero_cnt_q, zero_cnt_d;
   logic [OW-1:0] ones_cnt_q, ones_cnt_d;
   logic [SW-1:0] se0_cnt_q, se0_cnt_d;
   logic          data_q, data_d;
   logic          valid_q, valid_d;
   logic          sync_q, sync_d;
   logic          eop_q, eop_d;
   logic          err_q, err_d;
   logic          active_q, active_d;

   logic line_j_s;
   logic line_k_s;
   logic line_se0_s;
   logic line_jk_s;
   logic dec_bit_s;

   // Line-state classification; the J/K level is simply D+, and NRZI decodes "no change" as 1.
   assign line_j_s   = bus.i_dp & ~bus.i_dm;
   assign line_k_s   = ~bus.i_dp & bus.i_dm;
   assign line_se0_s = ~bus.i_dp & ~bus.i_dm;
   assign line_jk_s  = line_j_s | line_k_s;
   assign dec_bit_s  = (bus.i_dp == prev_level_q);

   // Next-state and output decode for the receive FSM.
   always_comb begin
      state_d      = state_q;
      prev_level_d = prev_level_q;
      zero_cnt_d   = zero_cnt_q;
      ones_cnt_d   = ones_cnt_q;
      se0_cnt_d    = se0_cnt_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      sync_d       = 1'b0;
      eop_d        = 1'b0;
      err_d        = 1'b0;
      active_d     = active_q;

      if (!bus.i_rx_en) begin
         state_d      = ST_IDLE;
         prev_level_d = 1'b1;
         zero_cnt_d   = '0;
         ones_cnt_d   = '0;
         se0_cnt_d    = '0;
         active_d     = 1'b0;
      end else if (bus.i_sample_valid) begin
         if (line_jk_s) begin
            prev_level_d = bus.i_dp;
         end else begin
            prev_level_d = prev_level_q;
         end

         case (state_q)
            ST_IDLE: begin
               if (line_jk_s) begin
                  if (dec_bit_s) begin
                     zero_cnt_d = '0;
                     if (zero_cnt_q >= ZERO_MAX) begin
                        sync_d     = 1'b1;
                        active_d   = 1'b1;
                        ones_cnt_d = OW'(1);
                        state_d    = ST_DATA;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else if (zero_cnt_q < ZERO_MAX) begin
                     zero_cnt_d = zero_cnt_q + ZW'(1);
                  end else begin
                     zero_cnt_d = ZERO_MAX;
                  end
               end else begin
                  zero_cnt_d = '0;
               end
            end

            ST_DATA: begin
               if (line_jk_s) begin
                  if (ones_cnt_q == STUFF_MAX) begin
                     // Stuffed-bit slot: a 0 is dropped, a 1 means seven ones in a row.
                     ones_cnt_d = '0;
                     if (dec_bit_s) begin
                        err_d    = 1'b1;
                        active_d = 1'b0;
                        state_d  = ST_ERR;
                     end else begin
                        state_d = ST_DATA;
                     end
                  end else begin
                     data_d  = dec_bit_s;
                     valid_d = 1'b1;
                     if (dec_bit_s) begin
                        ones_cnt_d = ones_cnt_q + OW'(1);
                     end else begin
                        ones_cnt_d = '0;
                     end
                  end
               end else if (line_se0_s) begin
                  ones_cnt_d = '0;
                  se0_cnt_d  = SW'(1);
                  state_d    = ST_EOP;
               end else begin
                  ones_cnt_d = '0;
                  err_d      = 1'b1;
                  active_d   = 1'b0;
                  state_d    = ST_ERR;
               end
            end

            ST_EOP: begin
               if (line_se0_s) begin
                  if (se0_cnt_q < SE0_MAX) begin
                     se0_cnt_d = se0_cnt_q + SW'(1);
                  end else begin
                     se0_cnt_d = SE0_MAX;
                  end
               end else if (line_j_s && (se0_cnt_q >= SE0_MAX)) begin
                  eop_d        = 1'b1;
                  active_d     = 1'b0;
                  se0_cnt_d    = '0;
                  prev_level_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  err_d     = 1'b1;
                  active_d  = 1'b0;
                  se0_cnt_d = '0;
                  state_d   = ST_ERR;
               end
            end

            ST_ERR: begin
               // Recovery needs the line to pass through SE0 and then settle on J.
               if (line_se0_s) begin
                  se0_cnt_d = SW'(1);
               end else if (line_j_s && (se0_cnt_q != '0)) begin
                  se0_cnt_d    = '0;
                  prev_level_d = 1'b1;
                  state_d      = ST_IDLE;
               end else begin
                  se0_cnt_d = '0;
               end
            end

            default: begin
               state_d      = ST_IDLE;
               prev_level_d = 1'b1;
               zero_cnt_d   = '0;
               ones_cnt_d   = '0;
               se0_cnt_d    = '0;
               active_d     = 1'b0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         prev_level_q <= 1'b1;
         zero_cnt_q   <= '0;
         ones_cnt_q   <= '0;
         se0_cnt_q    <= '0;
         data_q       <= 1'b0;
         valid_q      <= 1'b0;
         sync_q       <= 1'b0;
         eop_q        <= 1'b0;
         err_q        <= 1'b0;
         active_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_level_q <= prev_level_d;
         zero_cnt_q   <= zero_cnt_d;
         ones_cnt_q   <= ones_cnt_d;
         se0_cnt_q    <= se0_cnt_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         sync_q       <= sync_d;
         eop_q        <= eop_d;
         err_q        <= err_d;
         active_q     <= active_d;
      end
   end

   assign bus.o_data         = data_q;
   assign bus.o_valid        = valid_q;
   assign bus.o_sync_pattern = sync_q;
   assign bus.o_eop          = eop_q;
   assign bus.o_rx_error     = err_q;
   assign bus.o_active       = active_q;

endmodule

// File: doc/usb_rx_nrzi_decoder.md
Name: usb_rx_nrzi_decoder

Overview:
- Receive-path PHY stage directly upstream of the serial-to-parallel deserializer.
- Takes recovered, bit-rate line samples (D+/D-), NRZI-decodes them, hunts for SYNC, removes stuffed bits and detects EOP/line errors.
- Emits a clean one-bit data stream with a valid strobe and a SYNC-detected pulse, which drive the deserializer's i_data, i_valid and i_sync_pattern inputs.

Parameters:
- SYNC_MIN_ZEROS, 5: minimum consecutive decoded 0s that must precede the SYNC-terminating 1 (tolerates hub-truncated SYNC).
- EOP_MIN_SE0, 2: minimum consecutive SE0 samples that must precede J for a valid EOP.
- STUFF_LEN, 6: consecutive decoded 1s after which a stuffed 0 is mandatory.

Ports:
- i_clk, input, 1: clock.
- i_rst_n, input, 1: reset; asynchronous, active-low.
- i_dp, input, 1: synchronized D+ sample.
- i_dm, input, 1: synchronized D- sample.
- i_sample_valid, input, 1: one-cycle strobe per bit time; i_dp/i_dm are meaningful only when it is high.
- i_rx_en, input, 1: receiver enable; low forces IDLE.
- o_data, output, 1: decoded, unstuffed data bit.
- o_valid, output, 1: o_data is a payload bit (one-cycle pulse).
- o_sync_pattern, output, 1: SYNC detected (one-cycle pulse).
- o_eop, output, 1: valid EOP received (one-cycle pulse).
- o_rx_error, output, 1: stuffing violation, SE1, or short SE0 (one-cycle pulse).
- o_active, output, 1: high from SYNC detect until EOP or error.

Behaviour:
- Line states (full-speed polarity): J = dp1/dm0, K = dp0/dm1, SE0 = 00, SE1 = 11.
- NRZI decoding: compare current J/K level against prev_level. Same level decodes to 1; a change decodes to 0.
  - prev_level updates only on J/K samples.
  - prev_level resets to J and is forced to J on entering IDLE.
- Reset values: all outputs 0, state IDLE, all counters 0, prev_level J.
- Timing: all outputs are registered, with 1-cycle latency from the qualifying i_sample_valid cycle.
  - Pulse outputs are high for exactly one cycle.
  - Nothing changes in cycles where i_sample_valid is low; pulses return to 0 and o_data holds its value.
- i_rx_en low: next cycle state is IDLE, o_active is 0, counters clear, and no pulses are produced. This is checked before all other events.
- State IDLE/HUNT (the same state):
  - zero_cnt counts consecutive decoded 0s and saturates at SYNC_MIN_ZEROS.
  - A decoded 1 with zero_cnt >= SYNC_MIN_ZEROS: pulse o_sync_pattern, set o_active, set ones_cnt = 1 (the SYNC's final 1 counts toward stuffing), go to DATA.
  - A decoded 1 with fewer zeros clears zero_cnt.
  - SE0 and SE1 clear zero_cnt; no error is flagged in IDLE.
- State DATA, J/K sample with ones_cnt == STUFF_LEN (stuffed-bit position):
  - Decoded 0: dropped (no o_valid), ones_cnt = 0.
  - Decoded 1: pulse o_rx_error, clear o_active, go to ERR.
- State DATA, other J/K samples:
  - Output o_data = decoded bit with o_valid = 1.
  - ones_cnt increments on 1 and clears on 0.
- State DATA, SE0: go to EOP with se0_cnt = 1; no o_valid.
- State DATA, SE1: o_rx_error, go to ERR.
- State EOP:
  - SE0: se0_cnt++ (saturating).
  - J with se0_cnt >= EOP_MIN_SE0: pulse o_eop, clear o_active, go to IDLE.
  - J with se0_cnt < EOP_MIN_SE0, or K, or SE1: o_rx_error, go to ERR.
- State ERR: wait for SE0 followed by J, then go to IDLE silently (no o_eop). o_active stays 0.
- Simultaneous events:
  - Stuffing violation and SE1 are mutually exclusive per sample.
  - At most one of o_valid, o_sync_pattern, o_eop, o_rx_error is high in any cycle.
- Reset asserted mid-packet: immediate return to reset values, with no EOP or error pulse.

Test Plan:
- Idle J, then KJKJKJKK, then the bits of 0xA5 (LSB first): o_sync_pattern pulses once, then 8 o_valid pulses carrying 1,0,1,0,0,1,0,1, with o_active high.
- SYNC truncated to KJKJKK (5 zeros + 1): o_sync_pattern pulses. SYNC with only 3 leading zeros: no pulse and state stays IDLE.
- Payload of eight 1s with a stuffed 0 after the 6th 1 (counting the SYNC's 1, the stuff falls after five payload 1s): exactly eight o_valid=1 pulses, the stuffed bit is dropped, and no error.
- Seven consecutive decoded 1s at the stuff position: o_rx_error pulses and o_active drops. Subsequent SE0,SE0,J returns to IDLE with no o_eop; a following SYNC is detected again.
- After payload, SE0,SE0,J gives an o_eop pulse. SE0,J gives o_rx_error with no o_eop. An SE1 sample in DATA gives o_rx_error.
- i_sample_valid gaps of 0–3 idle cycles between samples: identical decoded output sequence.
- i_rst_n asserted mid-byte: all outputs go to 0 at once.
- i_rx_en dropped mid-packet: IDLE next cycle, no pulses.
